pipe_skid_stage: RTL

PIPE_SKID_STAGE -- requirements
Module: pipe_skid_stage

---
 rtl/pipe_pkg.sv | 39 +++
 rtl/pipe_perf_cnt.sv | 19 +
 rtl/pipe_skid_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared constants and types for the two-entry skid pipeline stage.
// Holds default widths, occupancy encodings and the per-cycle action decode.
package pipe_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_CNT_W  = 32;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

  // One mutually exclusive update per edge; the order of tests sets priority.
  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_LOAD_HEAD,
    ACT_LOAD_SKID,
    ACT_MOVE,
    ACT_RETIRE,
    ACT_FLUSH
  } act_e;

  function automatic act_e decode_action(
    input logic flush,
    input logic accept,
    input logic drain,
    input logic head_valid,
    input logic skid_valid
  );
    act_e act;
    if (flush)                            act = ACT_FLUSH;
    else if (drain && skid_valid)         act = ACT_MOVE;
    else if (accept && (!head_valid || drain)) act = ACT_LOAD_HEAD;
    else if (accept)                      act = ACT_LOAD_SKID;
    else if (drain)                       act = ACT_RETIRE;
    else                                  act = ACT_HOLD;
    return act;
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating up-counter with enable; sticks at all-ones once reached.
// Synchronous active-low reset.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (en && (cnt != '1))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry (head + skid) pipeline stage with registered in_allow and flush.
// Define PIPE_SKID_PERF_EN to add the stall_cnt / bubble_cnt performance counters.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validin,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_allow,
  input  logic              pipe_ready_go,
  input  logic              out_allow,
  output logic              validout,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [1:0]        occupancy
`ifdef PIPE_SKID_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  logic              head_valid, skid_valid;
  logic [DATA_W-1:0] head_data, skid_data;

  logic              nxt_head_valid, nxt_skid_valid;
  logic [DATA_W-1:0] nxt_head_data, nxt_skid_data;

  logic accept, drain;
  act_e act;

  // in_allow comes straight from a flop, so nothing downstream reaches it.
  assign in_allow  = !skid_valid;
  assign validout  = head_valid && pipe_ready_go;
  assign out_data  = head_data;
  assign accept    = validin && in_allow && !flush;
  assign drain     = validout && out_allow;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    nxt_head_valid = head_valid;
    nxt_skid_valid = skid_valid;
    nxt_head_data  = head_data;
    nxt_skid_data  = skid_data;
    act = decode_action(flush, accept, drain, head_valid, skid_valid);

    unique case (act)
      ACT_LOAD_HEAD: begin
        nxt_head_valid = 1'b1;
        nxt_head_data  = in_data;
      end
      ACT_LOAD_SKID: begin
        nxt_skid_valid = 1'b1;
        nxt_skid_data  = in_data;
      end
      ACT_MOVE: begin
        nxt_head_data  = skid_data;
        nxt_skid_valid = 1'b0;
      end
      ACT_RETIRE: nxt_head_valid = 1'b0;
      ACT_FLUSH: begin
        nxt_head_valid = 1'b0;
        nxt_skid_valid = 1'b0;
      end
      default: ;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_valid <= 1'b0;
      skid_valid <= 1'b0;
      // NOTE: data registers are reset too, so out_data reads 0 straight after reset.
      head_data  <= '0;
      skid_data  <= '0;
    end else begin
      head_valid <= nxt_head_valid;
      skid_valid <= nxt_skid_valid;
      head_data  <= nxt_head_data;
      skid_data  <= nxt_skid_data;
    end
  end

  always_comb begin
    unique case ({head_valid, skid_valid})
      2'b00:   occupancy = OCC_EMPTY;
      2'b11:   occupancy = OCC_FULL;
      default: occupancy = OCC_ONE;
    endcase
  end

`ifdef PIPE_SKID_PERF_EN
  logic stall_en, bubble_en;
  assign stall_en  = validout && !out_allow;
  assign bubble_en = !head_valid;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (stall_en),
    .cnt   (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (bubble_en),
    .cnt   (bubble_cnt)
  );
`else
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule
